dcache_st_buffer: RTL and testbench

Cache-side initiator for the D-cache store-to-memory interface. It queues committed stores from the LSU in a FIFO and drains them one at a time onto dc2memSt*. For each store it waits for mem2dcStComplete before issuing the next. It also flags loads that address a pending store word, so the LSU can stall them.

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/st_buf_fifo.sv | 62 ++++++
 rtl/dcache_st_buffer.sv | 105 ++++++++++
 tb/tb_dcache_st_buffer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and default sizes for the D-cache store buffer.
package dcache_pkg;

    localparam int ST_BUF_DEPTH        = 8;
    // Word (8-byte) address of a 32-bit byte address.
    localparam int DCACHE_ST_ADDR_BITS = 29;
    localparam int SIZE_DATA           = 64;
    localparam int SIZE_DATA_BYTE      = SIZE_DATA / 8;

    typedef struct packed {
        logic [DCACHE_ST_ADDR_BITS-1:0] addr;
        logic [SIZE_DATA-1:0]           data;
        logic [SIZE_DATA_BYTE-1:0]      byteEn;
    } stBufEntry;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } stBufState;

endpackage

// File: rtl/st_buf_fifo.sv
// Store queue storage: circular entry array with head/tail/count and a
// per-entry valid vector. The head stays valid until it is popped, so the
// in-flight store remains visible to the load conflict search.
module st_buf_fifo
    import dcache_pkg::*;
#(
    parameter int DEPTH = ST_BUF_DEPTH
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        push,
    input  stBufEntry                                   push_entry,
    input  logic                                        pop,
    output stBufEntry                                   head_entry,
    output logic [$clog2(DEPTH+1)-1:0]                  count,
    output logic [DEPTH-1:0]                            valid,
    output logic [DEPTH-1:0][DCACHE_ST_ADDR_BITS-1:0]   entry_addr
);

    localparam int PTR_W = $clog2(DEPTH);

    stBufEntry        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Pointer, occupancy and valid bookkeeping; DEPTH is a power of 2 so
    // the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                tail        <= tail + 1'b1;
                valid[tail] <= 1'b1;
            end
            if (pop) begin
                head        <= head + 1'b1;
                valid[head] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry payload write; contents need no reset since valid gates them.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_entry;
    end

    assign head_entry = mem[head];

    for (genvar i = 0; i < DEPTH; i++) begin : g_addr
        assign entry_addr[i] = mem[i].addr;
    end

endmodule

// File: rtl/dcache_st_buffer.sv
// D-cache store buffer: queues committed LSU stores and drains them one at a
// time to memory, waiting for each write to complete before the next. Also
// flags loads that hit a pending store word.
module dcache_st_buffer
    import dcache_pkg::*;
#(
    parameter int DEPTH     = ST_BUF_DEPTH,
    // Widths must match the stBufEntry fields in dcache_pkg.
    parameter int ADDR_BITS = DCACHE_ST_ADDR_BITS,
    parameter int DATA_BITS = SIZE_DATA,
    parameter int BE_BITS   = SIZE_DATA_BYTE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stValid_i,
    input  logic [ADDR_BITS-1:0]         stAddr_i,
    input  logic [DATA_BITS-1:0]         stData_i,
    input  logic [BE_BITS-1:0]           stByteEn_i,
    output logic                         stReady_o,
    input  logic                         ldValid_i,
    input  logic [ADDR_BITS-1:0]         ldAddr_i,
    output logic                         ldConflict_o,
    output logic [ADDR_BITS-1:0]         dc2memStAddr_o,
    output logic [DATA_BITS-1:0]         dc2memStData_o,
    output logic [BE_BITS-1:0]           dc2memStByteEn_o,
    output logic                         dc2memStValid_o,
    input  logic                         mem2dcStComplete_i,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflowErr_o
);

    localparam int                CNT_W    = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    stBufState                          state;
    stBufEntry                          head_entry;
    stBufEntry                          push_entry;
    logic [DEPTH-1:0]                   valid;
    logic [DEPTH-1:0][ADDR_BITS-1:0]    entry_addr;
    logic [DEPTH-1:0]                   match;
    logic                               has_be;
    logic                               push;
    logic                               pop;

    assign has_be     = |stByteEn_i;
    // Registered count: a pop this cycle does not open a slot until next.
    assign stReady_o  = ~reset && (count_o < FULL_CNT);
    // All-zero byte enables carry no write, so they are silently dropped.
    assign push       = stValid_i && stReady_o && has_be;
    assign pop        = mem2dcStComplete_i && (state == ISSUE || state == WAIT);
    assign push_entry = '{addr: stAddr_i, data: stData_i, byteEn: stByteEn_i};

    st_buf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (count_o),
        .valid      (valid),
        .entry_addr (entry_addr)
    );

    // Issue FSM: latch head in IDLE, pulse in ISSUE, hold until completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            dc2memStAddr_o   <= '0;
            dc2memStData_o   <= '0;
            dc2memStByteEn_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count_o != '0) begin
                        state            <= ISSUE;
                        dc2memStAddr_o   <= head_entry.addr;
                        dc2memStData_o   <= head_entry.data;
                        dc2memStByteEn_o <= head_entry.byteEn;
                    end
                end
                ISSUE:   state <= mem2dcStComplete_i ? IDLE : WAIT;
                WAIT:    if (mem2dcStComplete_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overflow: a real store arrived with no room for it.
    always_ff @(posedge clk) begin
        if (reset)                                          overflowErr_o <= 1'b0;
        else if (stValid_i && has_be && count_o == FULL_CNT) overflowErr_o <= 1'b1;
    end

    // Word-granular address match against every live entry.
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign match[i] = valid[i] && (entry_addr[i] == ldAddr_i);
    end

    assign ldConflict_o    = ldValid_i && |match;
    assign dc2memStValid_o = (state == ISSUE);
    assign empty_o         = (count_o == '0) && (state == IDLE);

endmodule

// File: tb/tb_dcache_st_buffer.sv
// Directed bench for dcache_st_buffer: single store, fill/overflow/drain,
// load conflicts, push+pop at wrap, reset mid-flight, zero byte-enable.
module tb_dcache_st_buffer;
    import dcache_pkg::*;

    localparam int AW    = DCACHE_ST_ADDR_BITS;
    localparam int DW    = SIZE_DATA;
    localparam int BW    = SIZE_DATA_BYTE;
    localparam int DEPTH = ST_BUF_DEPTH;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stValid_i = 1'b0;
    logic [AW-1:0] stAddr_i = '0;
    logic [DW-1:0] stData_i = '0;
    logic [BW-1:0] stByteEn_i = '0;
    logic          stReady_o;
    logic          ldValid_i = 1'b0;
    logic [AW-1:0] ldAddr_i = '0;
    logic          ldConflict_o;
    logic [AW-1:0] dc2memStAddr_o;
    logic [DW-1:0] dc2memStData_o;
    logic [BW-1:0] dc2memStByteEn_o;
    logic          dc2memStValid_o;
    logic          mem2dcStComplete_i = 1'b0;
    logic          empty_o;
    logic [CW-1:0] count_o;
    logic          overflowErr_o;

    int            total = 0;
    int            bad = 0;
    logic [AW-1:0] pulse_q[$];
    int            base;
    int            pc;

    dcache_st_buffer dut (
        .clk                (clk),
        .reset              (reset),
        .stValid_i          (stValid_i),
        .stAddr_i           (stAddr_i),
        .stData_i           (stData_i),
        .stByteEn_i         (stByteEn_i),
        .stReady_o          (stReady_o),
        .ldValid_i          (ldValid_i),
        .ldAddr_i           (ldAddr_i),
        .ldConflict_o       (ldConflict_o),
        .dc2memStAddr_o     (dc2memStAddr_o),
        .dc2memStData_o     (dc2memStData_o),
        .dc2memStByteEn_o   (dc2memStByteEn_o),
        .dc2memStValid_o    (dc2memStValid_o),
        .mem2dcStComplete_i (mem2dcStComplete_i),
        .empty_o            (empty_o),
        .count_o            (count_o),
        .overflowErr_o      (overflowErr_o)
    );

    always #5 clk = ~clk;

    // Log every memory write pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (dc2memStValid_o) pulse_q.push_back(dc2memStAddr_o);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {32'hA5A5_0000 ^ 32'(a), 32'(a)};
    endfunction

    task automatic drive_st(input logic [AW-1:0] a, input logic [BW-1:0] be);
        stValid_i  = 1'b1;
        stAddr_i   = a;
        stData_i   = data_of(a);
        stByteEn_i = be;
        tick();
        stValid_i  = 1'b0;
        stByteEn_i = '0;
    endtask

    task automatic push(input logic [AW-1:0] a);
        for (int n = 0; n < 64 && !stReady_o; n++) tick();
        if (!stReady_o) chk("push_ready_timeout", stReady_o, 1);
        drive_st(a, 8'hFF);
    endtask

    task automatic drain;
        mem2dcStComplete_i = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (empty_o) break;
            tick();
        end
        mem2dcStComplete_i = 1'b0;
        chk("drain_empty", empty_o, 1);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_valid", dc2memStValid_o, 0);
        chk("rst_ready", stReady_o, 0);
        chk("rst_ovf", overflowErr_o, 0);
        chk("rst_addr", dc2memStAddr_o, 0);
        reset = 1'b0;
        tick();

        // Single store, pulse two cycles after enqueue
        stValid_i  = 1'b1;
        stAddr_i   = 29'h10;
        stData_i   = 64'h1122334455667788;
        stByteEn_i = 8'hFF;
        tick();
        stValid_i  = 1'b0;
        stByteEn_i = '0;
        chk("s1_count1", count_o, 1);
        chk("s1_nopulse", dc2memStValid_o, 0);
        tick();
        chk("s1_pulse", dc2memStValid_o, 1);
        chk("s1_addr", dc2memStAddr_o, 64'h10);
        chk("s1_data", dc2memStData_o, 64'h1122334455667788);
        chk("s1_be", dc2memStByteEn_o, 8'hFF);
        tick();
        chk("s1_pulse_off", dc2memStValid_o, 0);
        tick(); tick();
        chk("s1_busy", empty_o, 0);
        mem2dcStComplete_i = 1'b1;
        tick();
        mem2dcStComplete_i = 1'b0;
        chk("s1_count0", count_o, 0);
        chk("s1_empty", empty_o, 1);
        chk("s1_one_pulse", pulse_q.size(), 1);

        // Fill 8, overflow on 9th, drain in order
        base = pulse_q.size();
        for (int i = 0; i < 8; i++) push(AW'(i));
        chk("fill_count", count_o, 8);
        chk("fill_ready", stReady_o, 0);
        ldValid_i = 1'b1; ldAddr_i = 29'h5; #1;
        chk("fill_ld_hit", ldConflict_o, 1);
        ldValid_i = 1'b0;
        drive_st(29'h8, 8'hFF);
        chk("ovf_set", overflowErr_o, 1);
        chk("ovf_count", count_o, 8);
        drain();
        chk("fill_pulses", pulse_q.size() - base, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("fill_order%0d", i), pulse_q[base+i], i);
        chk("ovf_sticky", overflowErr_o, 1);

        // Load conflict
        push(29'h20);
        tick(); tick();
        ldValid_i = 1'b1; ldAddr_i = 29'h20; #1;
        chk("ld_hit", ldConflict_o, 1);
        ldAddr_i = 29'h21; #1;
        chk("ld_miss", ldConflict_o, 0);
        ldValid_i = 1'b0; ldAddr_i = 29'h20; #1;
        chk("ld_novalid", ldConflict_o, 0);
        mem2dcStComplete_i = 1'b1;
        tick();
        mem2dcStComplete_i = 1'b0;
        ldValid_i = 1'b1; #1;
        chk("ld_after_pop", ldConflict_o, 0);
        ldValid_i = 1'b0;

        // Push + pop together at count 3, 16 stores across the wrap
        base = pulse_q.size();
        push(29'h100); push(29'h101); push(29'h102);
        chk("pp_count3", count_o, 3);
        mem2dcStComplete_i = 1'b1;
        push(29'h103);
        chk("pp_hold3", count_o, 3);
        for (int i = 4; i < 16; i++) push(AW'(29'h100 + i));
        drain();
        chk("pp_pulses", pulse_q.size() - base, 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("pp_order%0d", i), pulse_q[base+i], 29'h100 + i);

        // Reset while waiting with 4 pending
        push(29'h200); push(29'h201); push(29'h202); push(29'h203);
        chk("rw_count4", count_o, 4);
        chk("rw_busy", empty_o, 0);
        reset = 1'b1; #1;
        chk("rw_ready_rst", stReady_o, 0);
        tick();
        chk("rw_count", count_o, 0);
        chk("rw_empty", empty_o, 1);
        chk("rw_valid", dc2memStValid_o, 0);
        chk("rw_addr", dc2memStAddr_o, 0);
        chk("rw_data", dc2memStData_o, 0);
        chk("rw_be", dc2memStByteEn_o, 0);
        chk("rw_ovf_clr", overflowErr_o, 0);
        ldValid_i = 1'b1; ldAddr_i = 29'h201; #1;
        chk("rw_ld", ldConflict_o, 0);
        ldValid_i = 1'b0;
        reset = 1'b0;
        pc = pulse_q.size();
        mem2dcStComplete_i = 1'b1;
        tick();
        mem2dcStComplete_i = 1'b0;
        repeat (6) tick();
        chk("rw_late_count", count_o, 0);
        chk("rw_late_empty", empty_o, 1);
        chk("rw_no_pulse", pulse_q.size(), pc);

        // Zero byte-enable stores
        drive_st(29'h300, 8'h00);
        chk("be0_count", count_o, 0);
        chk("be0_empty", empty_o, 1);
        base = pulse_q.size();
        for (int i = 0; i < 8; i++) push(AW'(29'h400 + i));
        drive_st(29'h300, 8'h00);
        chk("be0_full_count", count_o, 8);
        chk("be0_full_ovf", overflowErr_o, 0);
        drain();
        chk("be0_pulses", pulse_q.size() - base, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
